// File: rtl/sram_avn_responder.sv
// rtl/sram_avn_responder.sv - Avalon-MM responder posting writes through a FIFO to an async SRAM
// Reads drain all posted writes first, then run a timed output-enable cycle.

module sram_avn_fifo #(
  parameter int AW    = 19,
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic          empty,
  output logic          full
);

  localparam int PW = $clog2(DEPTH);

  logic [AW+DW-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign {head_addr, head_data} = mem[rd_ptr];

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {push_addr, push_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

endmodule

module sram_avn_responder #(
  parameter int AVN_AW     = 19,
  parameter int AVN_DW     = 16,
  parameter int SRAM_AW    = 20,
  parameter int FIFO_DEPTH = 4,
  parameter int WR_CYCLES  = 2,
  parameter int RD_CYCLES  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [AVN_AW-1:0]  avn_address,
  input  logic               avn_write,
  input  logic [AVN_DW-1:0]  avn_writedata,
  input  logic               avn_read,
  output logic [AVN_DW-1:0]  avn_readdata,
  output logic               avn_waitrequest,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [AVN_DW-1:0]  sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [AVN_DW-1:0]  sram_dq_in,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_lb_n,
  output logic               sram_ub_n
);

  localparam int MAXC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] WR_LAST = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WREC,
    S_READ,
    S_RD_RESP
  } state_t;

  state_t state_q;
  state_t state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [AVN_AW-1:0] fifo_head_addr;
  logic [AVN_DW-1:0] fifo_head_data;

  logic [SRAM_AW-1:0] addr_d;
  logic [AVN_DW-1:0]  dq_out_d;
  logic [AVN_DW-1:0]  rdata_d;
  logic               dq_oe_d;
  logic               ce_n_d;
  logic               oe_n_d;
  logic               we_n_d;

  function automatic logic [SRAM_AW-1:0] zext(input logic [AVN_AW-1:0] a);
    logic [SRAM_AW-1:0] r;
    r = '0;
    r[AVN_AW-1:0] = a;
    return r;
  endfunction

  // Fullness comes from the registered count, so a same-cycle pop never frees a slot.
  assign avn_waitrequest = (avn_write & fifo_full)
                         | (avn_read & (state_q != S_RD_RESP))
                         | (avn_write & avn_read);
  assign fifo_push = avn_write & ~avn_waitrequest;

  assign sram_lb_n = 1'b0;
  assign sram_ub_n = 1'b0;

  sram_avn_fifo #(
    .AW    (AVN_AW),
    .DW    (AVN_DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_addr (avn_address),
    .push_data (avn_writedata),
    .pop       (fifo_pop),
    .head_addr (fifo_head_addr),
    .head_data (fifo_head_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Posted writes always win over a waiting read, which keeps read-after-write order.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = S_WRITE;
          cnt_d    = '0;
        end else if (avn_read) begin
          state_d = S_READ;
          cnt_d   = '0;
        end
      end
      S_WRITE: begin
        if (cnt_q == WR_LAST) begin
          state_d = S_WREC;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WREC: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = S_WRITE;
          cnt_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (cnt_q == RD_LAST) begin
          state_d = S_RD_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RD_RESP: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d   = sram_addr;
    dq_out_d = sram_dq_out;
    dq_oe_d  = sram_dq_oe;
    ce_n_d   = sram_ce_n;
    oe_n_d   = sram_oe_n;
    we_n_d   = sram_we_n;
    rdata_d  = avn_readdata;
    if (fifo_pop) begin
      addr_d   = zext(fifo_head_addr);
      dq_out_d = fifo_head_data;
      dq_oe_d  = 1'b1;
      ce_n_d   = 1'b0;
      oe_n_d   = 1'b1;
      we_n_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (state_d == S_READ) begin
            addr_d = zext(avn_address);
            ce_n_d = 1'b0;
            oe_n_d = 1'b0;
          end
        end
        S_WRITE: begin
          if (state_d == S_WREC) begin
            we_n_d = 1'b1;
          end
        end
        S_WREC: begin
          dq_oe_d = 1'b0;
          ce_n_d  = 1'b1;
        end
        S_READ: begin
          if (state_d == S_RD_RESP) begin
            rdata_d = sram_dq_in;
            oe_n_d  = 1'b1;
            ce_n_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_addr    <= '0;
      sram_dq_out  <= '0;
      sram_dq_oe   <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      avn_readdata <= '0;
    end else begin
      sram_addr    <= addr_d;
      sram_dq_out  <= dq_out_d;
      sram_dq_oe   <= dq_oe_d;
      sram_ce_n    <= ce_n_d;
      sram_oe_n    <= oe_n_d;
      sram_we_n    <= we_n_d;
      avn_readdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_avn_responder.sv
// tb/tb_sram_avn_responder.sv - random and directed bench for sram_avn_responder
// SRAM model plus a write scoreboard and a reference memory for read data.

module tb_sram_avn_responder;

  localparam int AVN_AW     = 19;
  localparam int AVN_DW     = 16;
  localparam int SRAM_AW    = 20;
  localparam int FIFO_DEPTH = 4;
  localparam int WR_CYCLES  = 2;
  localparam int RD_CYCLES  = 2;

  logic               clk;
  logic               rst_n;
  logic [AVN_AW-1:0]  avn_address;
  logic               avn_write;
  logic [AVN_DW-1:0]  avn_writedata;
  logic               avn_read;
  logic [AVN_DW-1:0]  avn_readdata;
  logic               avn_waitrequest;
  logic [SRAM_AW-1:0] sram_addr;
  logic [AVN_DW-1:0]  sram_dq_out;
  logic               sram_dq_oe;
  logic [AVN_DW-1:0]  sram_dq_in;
  logic               sram_ce_n;
  logic               sram_oe_n;
  logic               sram_we_n;
  logic               sram_lb_n;
  logic               sram_ub_n;

  sram_avn_responder #(
    .AVN_AW     (AVN_AW),
    .AVN_DW     (AVN_DW),
    .SRAM_AW    (SRAM_AW),
    .FIFO_DEPTH (FIFO_DEPTH),
    .WR_CYCLES  (WR_CYCLES),
    .RD_CYCLES  (RD_CYCLES)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .avn_address     (avn_address),
    .avn_write       (avn_write),
    .avn_writedata   (avn_writedata),
    .avn_read        (avn_read),
    .avn_readdata    (avn_readdata),
    .avn_waitrequest (avn_waitrequest),
    .sram_addr       (sram_addr),
    .sram_dq_out     (sram_dq_out),
    .sram_dq_oe      (sram_dq_oe),
    .sram_dq_in      (sram_dq_in),
    .sram_ce_n       (sram_ce_n),
    .sram_oe_n       (sram_oe_n),
    .sram_we_n       (sram_we_n),
    .sram_lb_n       (sram_lb_n),
    .sram_ub_n       (sram_ub_n)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int wr_count = 0;
  int burst_t0 = 0;
  int low_len = 0;
  int cur_addr = 0;
  bit prev_we = 1'b1;
  logic [15:0] cur_data;

  logic [18:0] wa [16];
  logic [15:0] wd [16];
  int          acc_at [16];
  logic [35:0] exp_q [$];
  int          we_fall_q [$];
  logic [15:0] ref_mem [int];
  logic [15:0] sram_mem [int];
  logic [18:0] pool [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accept cycle of write i in a back-to-back burst from idle: pop k lands at 1+(WR+1)k,
  // and a push needs fewer than FIFO_DEPTH entries counted at the start of its cycle.
  function automatic int exp_accept(input int i, input int prev);
    int lim;
    lim = 0;
    if (i == 0) return 0;
    if (i >= FIFO_DEPTH) lim = 2 + (WR_CYCLES + 1) * (i - FIFO_DEPTH);
    return (prev + 1 > lim) ? prev + 1 : lim;
  endfunction

  // SRAM model and write scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_we = 1'b1;
      low_len = 0;
    end else begin
      if (!sram_we_n) begin
        if (prev_we) we_fall_q.push_back(cyc);
        low_len++;
        cur_addr = int'(sram_addr);
        cur_data = sram_dq_out;
        check_eq("wr_ce_n", 32'(sram_ce_n), 32'd0);
        check_eq("wr_dq_oe", 32'(sram_dq_oe), 32'd1);
        check_eq("wr_oe_n", 32'(sram_oe_n), 32'd1);
      end else if (!prev_we) begin
        logic [35:0] e;
        wr_count++;
        check_eq("wr_pulse_len", low_len, WR_CYCLES);
        if (exp_q.size() == 0) begin
          check_eq("wr_spurious", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check_eq("wr_addr", cur_addr, 32'(e[35:16]));
          check_eq("wr_data", 32'(cur_data), 32'(e[15:0]));
        end
        sram_mem[cur_addr] = cur_data;
        low_len = 0;
      end
      prev_we = sram_we_n;
    end
    if (!sram_oe_n && !sram_ce_n) begin
      sram_dq_in = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : 16'h0000;
    end else begin
      sram_dq_in = 16'h5A5A;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input int n);
    int i;
    int guard;
    i = 0;
    guard = 0;
    burst_t0 = cyc;
    while (i < n && guard < 400) begin
      avn_write = 1'b1;
      avn_read = 1'b0;
      avn_address = wa[i];
      avn_writedata = wd[i];
      @(negedge clk);
      if (!avn_waitrequest) begin
        acc_at[i] = cyc - burst_t0;
        exp_q.push_back({1'b0, wa[i], wd[i]});
        ref_mem[int'(wa[i])] = wd[i];
        i++;
      end
      step();
      guard++;
    end
    avn_write = 1'b0;
    if (i < n) check_eq("wr_burst_timeout", i, n);
  endtask

  task automatic do_read(input logic [18:0] a, input bit hold, output logic [15:0] d, output int lat);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    d = '0;
    lat = -1;
    avn_read = 1'b1;
    avn_write = 1'b0;
    avn_address = a;
    while (!done && n < 200) begin
      @(negedge clk);
      if (!avn_waitrequest) begin
        d = avn_readdata;
        lat = n;
        done = 1'b1;
      end
      step();
      n++;
    end
    if (done && hold) begin
      @(negedge clk);
      check_eq("rd_wait_once", 32'(avn_waitrequest), 32'd1);
      step();
    end
    avn_read = 1'b0;
    if (!done) check_eq("rd_timeout", 32'(done), 32'd1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      step();
      g++;
    end
    check_eq("drain", exp_q.size(), 0);
    repeat (3) step();
  endtask

  initial begin
    logic [15:0] d;
    int lat;
    int n0;
    int prev;

    rst_n = 1'b0;
    avn_write = 1'b0;
    avn_read = 1'b0;
    avn_address = '0;
    avn_writedata = '0;
    sram_dq_in = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ce_n", 32'(sram_ce_n), 32'd1);
    check_eq("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check_eq("rst_we_n", 32'(sram_we_n), 32'd1);
    check_eq("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check_eq("rst_addr", 32'(sram_addr), 32'd0);
    check_eq("rst_dq_out", 32'(sram_dq_out), 32'd0);
    check_eq("rst_readdata", 32'(avn_readdata), 32'd0);
    check_eq("rst_waitreq", 32'(avn_waitrequest), 32'd0);
    check_eq("byte_en", 32'({sram_lb_n, sram_ub_n}), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single write: we_n low in cycles 2-3, recovery in 4, idle in 5.
    wa[0] = 19'h12345;
    wd[0] = 16'hBEEF;
    write_burst(1);
    @(negedge clk);
    check_eq("sw_c1_we_n", 32'(sram_we_n), 32'd1);
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      check_eq("sw_addr", 32'(sram_addr), 32'h12345);
      check_eq("sw_dq_out", 32'(sram_dq_out), 32'hBEEF);
      check_eq("sw_dq_oe", 32'(sram_dq_oe), 32'd1);
      check_eq("sw_we_n", 32'(sram_we_n), 32'd0);
    end
    @(negedge clk);
    check_eq("sw_wrec_we_n", 32'(sram_we_n), 32'd1);
    check_eq("sw_wrec_ce_n", 32'(sram_ce_n), 32'd0);
    @(negedge clk);
    check_eq("sw_idle_ce_n", 32'(sram_ce_n), 32'd1);
    check_eq("sw_idle_dq_oe", 32'(sram_dq_oe), 32'd0);
    step();
    drain();

    // Idle read: stalled for RD_CYCLES+1 cycles, then data.
    sram_mem[int'(20'h0ABCD)] = 16'h1234;
    do_read(19'h0ABCD, 1'b0, d, lat);
    check_eq("idle_rd_data", 32'(d), 32'h1234);
    check_eq("idle_rd_lat", lat, RD_CYCLES + 1);
    repeat (3) step();

    // Read-after-write: read waits for the posted write to land.
    wa[0] = 19'h00010;
    wd[0] = 16'hA5A5;
    write_burst(1);
    do_read(19'h00010, 1'b1, d, lat);
    check_eq("raw_data", 32'(d), 32'hA5A5);
    check_eq("raw_lat", lat, WR_CYCLES + RD_CYCLES + 3);
    repeat (10) step();

    // Simultaneous read and write: stalled, nothing written.
    n0 = wr_count;
    avn_write = 1'b1;
    avn_read = 1'b1;
    avn_address = 19'h00777;
    avn_writedata = 16'hDEAD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("perr_wait", 32'(avn_waitrequest), 32'd1);
      step();
    end
    avn_write = 1'b0;
    avn_read = 1'b0;
    repeat (10) step();
    check_eq("perr_no_write", wr_count, n0);
    @(negedge clk);
    check_eq("noreq_wait", 32'(avn_waitrequest), 32'd0);
    step();

    // Back-to-back burst of 8 overflows the FIFO.
    we_fall_q.delete();
    for (int i = 0; i < 8; i++) begin
      wa[i] = 19'(32'h00100 + i * 7);
      wd[i] = 16'($urandom);
    end
    write_burst(8);
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      prev = exp_accept(i, prev);
      check_eq($sformatf("burst_acc%0d", i), acc_at[i], prev);
    end
    drain();
    check_eq("burst_nwr", we_fall_q.size(), 8);
    for (int i = 0; i < 8 && i < we_fall_q.size(); i++) begin
      check_eq($sformatf("burst_we_at%0d", i), we_fall_q[i] - burst_t0, 2 + i * (WR_CYCLES + 1));
    end

    // Reset in WRITE with 3 entries queued discards everything.
    for (int i = 0; i < 5; i++) begin
      wa[i] = 19'(32'h7FF00 + i);
      wd[i] = 16'($urandom);
    end
    write_burst(5);
    check_eq("rst_pre_we_n", 32'(sram_we_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_we_n", 32'(sram_we_n), 32'd1);
    check_eq("rst_async_ce_n", 32'(sram_ce_n), 32'd1);
    check_eq("rst_async_dq_oe", 32'(sram_dq_oe), 32'd0);
    exp_q.delete();
    n0 = wr_count;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (20) step();
    check_eq("rst_no_writes", wr_count, n0);
    wa[0] = 19'h00042;
    wd[0] = 16'h4242;
    write_burst(1);
    check_eq("rst_new_write_acc", acc_at[0], 0);
    drain();

    // Randomized traffic over a small address pool.
    for (int k = 0; k < 8; k++) begin
      pool[k] = 19'($urandom_range(0, 307199));
      wa[0] = pool[k];
      wd[0] = 16'($urandom);
      write_burst(1);
    end
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 2) < 2) begin
        int n;
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) begin
          wa[i] = pool[$urandom_range(0, 7)];
          wd[i] = 16'($urandom);
        end
        write_burst(n);
      end else begin
        logic [18:0] a;
        logic [15:0] e;
        a = pool[$urandom_range(0, 7)];
        e = ref_mem[int'(a)];
        do_read(a, 1'b0, d, lat);
        check_eq("rnd_rd_data", 32'(d), 32'(e));
        check_eq("rnd_rd_min_lat", 32'(lat >= RD_CYCLES + 1), 32'd1);
      end
      repeat ($urandom_range(0, 3)) step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_avn_responder.md
Name: sram_avn_responder

Overview:
Avalon-MM responder (slave) that terminates the pixel write stream produced by the Mandelbrot render engine and the framebuffer read requests, and drives an external asynchronous 16-bit SRAM. Writes are posted through a small FIFO so the render engine stalls only when the FIFO is full. Reads drain the FIFO first, which preserves ordering, and then run a timed SRAM read cycle. The block sits between the render/VGA masters and the SRAM pins.

Parameters:
AVN_AW, 19, Avalon word address width (640x480 = 307200 words)
AVN_DW, 16, Avalon data width, equal to the SRAM data width
SRAM_AW, 20, SRAM address width; must be >= AVN_AW, and avn_address is zero-extended
FIFO_DEPTH, 4, posted-write FIFO entries; must be a power of 2 and >= 2
WR_CYCLES, 2, cycles sram_we_n is held low per write; must be >= 1
RD_CYCLES, 2, cycles sram_oe_n is held low before data capture; must be >= 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
avn_address  in  AVN_AW  word address
avn_write  in  1  write request
avn_writedata  in  AVN_DW  write data
avn_read  in  1  read request
avn_readdata  out  AVN_DW  read data, valid when avn_read=1 and avn_waitrequest=0
avn_waitrequest  out  1  stall; the request is accepted in the cycle where it is low
sram_addr  out  SRAM_AW  SRAM address
sram_dq_out  out  AVN_DW  SRAM data out
sram_dq_oe  out  1  tristate enable for sram_dq_out
sram_dq_in  in  AVN_DW  SRAM data in
sram_ce_n  out  1  chip enable
sram_oe_n  out  1  output enable
sram_we_n  out  1  write enable
sram_lb_n  out  1  lower byte enable, tied 0 (full-word access only)
sram_ub_n  out  1  upper byte enable, tied 0 (full-word access only)

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state:
  - FSM in IDLE, FIFO empty.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0.
  - sram_addr=0, sram_dq_out=0, avn_readdata=0.
  - Reset mid-access aborts the access immediately; the write in progress and all FIFO contents are discarded.
- All sram_* outputs and avn_readdata are registered.
- avn_waitrequest is combinational: (avn_write & fifo_full) | (avn_read & ~(state==RD_RESP)) | (avn_write & avn_read). It is 0 when there is no request.
- Write accept:
  - avn_write=1 with waitrequest=0 pushes {address, writedata} into the FIFO.
  - Fullness is evaluated at the start of the cycle. A pop in the same cycle does not free a slot for that cycle's push.
- Simultaneous avn_read and avn_write is a protocol error. Both are stalled and nothing is accepted.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head, load sram_addr and sram_dq_out, set dq_oe=1, ce_n=0, we_n=0, and go to WRITE. Otherwise, if avn_read is asserted, load sram_addr, set ce_n=0, oe_n=0, and go to READ.
  - WRITE: hold for WR_CYCLES cycles with we_n=0, then go to WREC with we_n=1 (data and address still held).
  - WREC: one cycle. If the FIFO is non-empty, pop and go to WRITE directly. Otherwise set dq_oe=0, ce_n=1, and go to IDLE.
  - READ: hold oe_n=0 for RD_CYCLES cycles. On the last cycle, capture sram_dq_in into avn_readdata, set oe_n=1, ce_n=1, and go to RD_RESP.
  - RD_RESP: one cycle with waitrequest=0 for the read, then return to IDLE.
- Write throughput: one SRAM write per WR_CYCLES+1 cycles in steady state.
- Write latency: a push in cycle 0 is poppable in cycle 1; we_n is low from cycle 2.
- Read latency with an empty FIFO and IDLE, read asserted in cycle 0:
  - waitrequest is high in cycles 0..RD_CYCLES.
  - waitrequest is low in cycle RD_CYCLES+1, with data valid.
- Writes have priority over reads. A pending read waits until the FIFO is empty and the FSM returns to IDLE. This gives read-after-write ordering.
- The FIFO pointers wrap modulo FIFO_DEPTH. Occupancy uses a count of width log2(FIFO_DEPTH)+1.

Test Plan:
- Reset mid-write: assert rst_n=0 while in WRITE with 3 FIFO entries -> we_n=1, ce_n=1, dq_oe=0 asynchronously. After release, no further SRAM writes occur and waitrequest=0 for a new write.
- Single write, WR_CYCLES=2: addr 0x12345, data 0xBEEF pushed in cycle 0 -> in cycles 2-3, sram_addr=0x12345, dq_out=0xBEEF, dq_oe=1, we_n=0. Cycle 4 is WREC with we_n=1. Cycle 5 is IDLE with ce_n=1.
- Burst of 6 back-to-back writes, FIFO_DEPTH=4 -> waitrequest rises once the FIFO is full. All 6 writes appear at the SRAM in order, spaced 3 cycles apart, and no write is lost or duplicated.
- Read-after-write: write 0x00010=0xA5A5, then assert a read of 0x00010 on the next cycle -> the read stalls until the write completes. The SRAM model returns 0xA5A5, and waitrequest is low for exactly one cycle.
- Idle read, RD_CYCLES=2, SRAM word 0x0ABCD=0x1234 -> waitrequest is high in cycles 0-2, and in cycle 3 waitrequest=0 with readdata=0x1234.
- System test: mandelbrot_render as master with max_iteration=16, rendering a full frame -> 307200 writes reach the SRAM model with addresses 0..307199, each written once, and the render engine stalls only while the FIFO is full.
